// File: rtl/fde_pkg.sv
// Shared definitions for the fetch/decode/execute pipeline: op one-hot bit
// indices, ID_EX / EX_MEM field layout and the execute-stage state encoding.
package fde_pkg;

  localparam int OP_W = 16;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_LI  = 2;
  localparam int OP_SHL = 3;
  localparam int OP_SHR = 4;
  localparam int OP_AND = 5;
  localparam int OP_OR  = 6;
  localparam int OP_XOR = 7;
  localparam int OP_BR  = 8;
  localparam int OP_BNE = 9;
  localparam int OP_MOV = 10;
  localparam int OP_ADI = 11;
  localparam int OP_MUL = 12;
  localparam int OP_HLT = 13;
  localparam int OP_NOP = 14;

  localparam logic [OP_W-1:0] OP_NOP_CODE = 16'h4000;

  // ID_EX bus layout (decode -> execute)
  localparam int IDEX_W         = 176;
  localparam int IDEX_WORD_W    = 32;
  localparam int IDEX_INSTR_LSB = 0;
  localparam int IDEX_PC_LSB    = 32;
  localparam int IDEX_RS_LSB    = 64;
  localparam int IDEX_RT_LSB    = 96;
  localparam int IDEX_IMM_LSB   = 128;
  localparam int IDEX_OP_LSB    = 160;

  // EX_MEM bus layout (execute -> writeback)
  localparam int EXMEM_W          = 86;
  localparam int EXMEM_RESULT_LSB = 0;
  localparam int EXMEM_PC_LSB     = 32;
  localparam int EXMEM_DEST_LSB   = 64;
  localparam int EXMEM_DEST_W     = 5;
  localparam int EXMEM_WEN_BIT    = 69;
  localparam int EXMEM_OP_LSB     = 70;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_BUSY = 2'd1,
    HALT     = 2'd2
  } ex_state_t;

  // True when exactly one op bit is set.
  function automatic logic op_is_one_hot(input logic [OP_W-1:0] op);
    return (op != '0) && ((op & (op - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier producing the low XLEN bits of the product.
// One iteration per clock after start; o_done flags the cycle in which the
// final iteration happens, with o_product already holding the final sum so
// the caller can capture it on that same edge.
module seq_multiplier #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_mcand,
  input  logic [XLEN-1:0] i_mplier,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_product
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(MUL_CYCLES - 1);

  logic            r_busy;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;

  logic [XLEN-1:0] w_addend;
  logic [XLEN-1:0] w_accNext;

  assign w_addend  = r_mplier[0] ? r_mcand : '0;
  assign w_accNext = r_acc + w_addend;

  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_count == LAST_ITER);
  assign o_product = w_accNext;

  // Load operands on start, then add/shift once per cycle until the last iteration.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy   <= 1'b0;
      r_count  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_count  <= '0;
      r_mcand  <= i_mcand;
      r_mplier <= i_mplier;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_accNext;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (o_done) begin
        r_busy <= 1'b0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: decodes the one-hot op from ID_EX, runs single-cycle ALU and
// branch ops, hands MUL to the sequential multiplier, and registers the
// outcome onto EX_MEM. MUL_CYCLES is expected to equal XLEN so the
// multiplier consumes every multiplier bit.
module execute_stage
  import fde_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [IDEX_W-1:0]  ID_EX,
  input  logic               id_valid,
  output logic               stall,
  output logic [EXMEM_W-1:0] EX_MEM,
  output logic               ex_valid,
  output logic               branch_taken,
  output logic [31:0]        branch_target,
  output logic               halted,
  output logic               ex_illegal
);

  logic [XLEN-1:0]         w_instr;
  logic [XLEN-1:0]         w_pc;
  logic [XLEN-1:0]         w_rs;
  logic [XLEN-1:0]         w_rt;
  logic [XLEN-1:0]         w_imm;
  logic [OP_W-1:0]         w_op;
  logic                    w_legal;
  logic [OP_W-1:0]         w_opEff;
  logic [4:0]              w_rdField;
  logic [4:0]              w_rtField;
  logic [4:0]              w_shamt;
  logic                    w_unusedBits;
  logic                    w_accept;
  logic                    w_mulStart;
  logic                    w_isBranch;
  logic [XLEN-1:0]         w_target;
  logic [XLEN-1:0]         w_result;
  logic [EXMEM_DEST_W-1:0] w_dest;
  logic                    w_wen;
  logic                    w_taken;
  logic                    w_mulBusy;
  logic                    w_mulDone;
  logic [XLEN-1:0]         w_mulProduct;

  ex_state_t               r_state;
  logic [EXMEM_W-1:0]      r_exMem;
  logic                    r_exValid;
  logic                    r_branchTaken;
  logic [31:0]             r_branchTarget;
  logic                    r_halted;
  logic                    r_exIllegal;
  logic [XLEN-1:0]         r_mulPc;
  logic [EXMEM_DEST_W-1:0] r_mulDest;

  assign w_instr = ID_EX[IDEX_INSTR_LSB +: IDEX_WORD_W];
  assign w_pc    = ID_EX[IDEX_PC_LSB    +: IDEX_WORD_W];
  assign w_rs    = ID_EX[IDEX_RS_LSB    +: IDEX_WORD_W];
  assign w_rt    = ID_EX[IDEX_RT_LSB    +: IDEX_WORD_W];
  assign w_imm   = ID_EX[IDEX_IMM_LSB   +: IDEX_WORD_W];
  assign w_op    = ID_EX[IDEX_OP_LSB    +: OP_W];

  assign w_rdField    = w_instr[15:11];
  assign w_rtField    = w_instr[20:16];
  assign w_shamt      = w_instr[10:6];
  assign w_unusedBits = ^{w_instr[31:21], w_instr[5:0]};

  // Anything that is not exactly one-hot executes as a NOP.
  assign w_legal = op_is_one_hot(w_op);
  assign w_opEff = w_legal ? w_op : OP_NOP_CODE;

  assign stall      = (r_state == MUL_BUSY) | (r_state == HALT);
  assign w_accept   = id_valid && (r_state == RUN);
  assign w_mulStart = w_accept && w_opEff[OP_MUL];

  assign w_isBranch = w_opEff[OP_BR] | w_opEff[OP_BNE];
  assign w_target   = w_pc + 32'd4 + (w_imm << 2);

  // Single-cycle result, destination and write-enable for the accepted op.
  always_comb begin
    w_result = '0;
    w_dest   = '0;
    w_wen    = 1'b0;
    w_taken  = 1'b0;
    if (w_opEff[OP_ADD]) begin
      w_result = w_rs + w_rt;
      w_dest   = w_rdField;
      w_wen    = 1'b1;
    end
    if (w_opEff[OP_SUB]) begin
      w_result = w_rs - w_rt;
      w_dest   = w_rdField;
      w_wen    = 1'b1;
    end
    if (w_opEff[OP_LI]) begin
      w_result = w_imm;
      w_dest   = w_rtField;
      w_wen    = 1'b1;
    end
    if (w_opEff[OP_SHL]) begin
      w_result = w_rt << w_shamt;
      w_dest   = w_rdField;
      w_wen    = 1'b1;
    end
    if (w_opEff[OP_SHR]) begin
      w_result = w_rt >> w_shamt;
      w_dest   = w_rdField;
      w_wen    = 1'b1;
    end
    if (w_opEff[OP_AND]) begin
      w_result = w_rs & w_rt;
      w_dest   = w_rdField;
      w_wen    = 1'b1;
    end
    if (w_opEff[OP_OR]) begin
      w_result = w_rs | w_rt;
      w_dest   = w_rdField;
      w_wen    = 1'b1;
    end
    if (w_opEff[OP_XOR]) begin
      w_result = w_rs ^ w_rt;
      w_dest   = w_rdField;
      w_wen    = 1'b1;
    end
    if (w_opEff[OP_BR]) begin
      w_taken = 1'b1;
    end
    if (w_opEff[OP_BNE]) begin
      w_taken = (w_rs != w_rt);
    end
    if (w_opEff[OP_MOV]) begin
      w_result = w_rs;
      w_dest   = w_rdField;
      w_wen    = 1'b1;
    end
    if (w_opEff[OP_ADI]) begin
      w_result = w_rs + w_imm;
      w_dest   = w_rtField;
      w_wen    = 1'b1;
    end
    if (w_opEff[OP_MUL]) begin
      w_dest = w_rdField;
      w_wen  = 1'b1;
    end
  end

  seq_multiplier #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_start   (w_mulStart),
    .i_mcand   (w_rs),
    .i_mplier  (w_rt),
    .o_busy    (w_mulBusy),
    .o_done    (w_mulDone),
    .o_product (w_mulProduct)
  );

  // Execute-stage state machine: accepts ops in RUN, waits out MUL, parks in HALT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= RUN;
      r_exMem        <= '0;
      r_exValid      <= 1'b0;
      r_branchTaken  <= 1'b0;
      r_branchTarget <= '0;
      r_halted       <= 1'b0;
      r_exIllegal    <= 1'b0;
      r_mulPc        <= '0;
      r_mulDest      <= '0;
    end else begin
      r_exValid     <= 1'b0;
      r_branchTaken <= 1'b0;
      r_exIllegal   <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_accept) begin
            if (w_opEff[OP_MUL]) begin
              r_state   <= MUL_BUSY;
              r_mulPc   <= w_pc;
              r_mulDest <= w_dest;
            end else begin
              r_exMem[EXMEM_RESULT_LSB +: 32]          <= w_result;
              r_exMem[EXMEM_PC_LSB +: 32]              <= w_pc;
              r_exMem[EXMEM_DEST_LSB +: EXMEM_DEST_W]  <= w_dest;
              r_exMem[EXMEM_WEN_BIT]                   <= w_wen;
              r_exMem[EXMEM_OP_LSB +: OP_W]            <= w_opEff;
              r_exValid      <= 1'b1;
              r_branchTaken  <= w_taken;
              r_branchTarget <= w_isBranch ? w_target : '0;
              r_exIllegal    <= ~w_legal;
              if (w_opEff[OP_HLT]) begin
                r_state  <= HALT;
                r_halted <= 1'b1;
              end
            end
          end
        end
        MUL_BUSY: begin
          if (w_mulDone) begin
            r_exMem[EXMEM_RESULT_LSB +: 32]         <= w_mulProduct;
            r_exMem[EXMEM_PC_LSB +: 32]             <= r_mulPc;
            r_exMem[EXMEM_DEST_LSB +: EXMEM_DEST_W] <= r_mulDest;
            r_exMem[EXMEM_WEN_BIT]                  <= 1'b1;
            r_exMem[EXMEM_OP_LSB +: OP_W]           <= 16'h1000;
            r_exValid      <= 1'b1;
            r_branchTarget <= '0;
            r_state        <= RUN;
          end else if (!w_mulBusy) begin
            r_state <= RUN;
          end
        end
        HALT: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign EX_MEM        = r_exMem;
  assign ex_valid      = r_exValid;
  assign branch_taken  = r_branchTaken;
  assign branch_target = r_branchTarget;
  assign halted        = r_halted;
  assign ex_illegal    = r_exIllegal;

endmodule
